audio_in_frame_reader: RTL and testbench
========================================

Name: audio_in_frame_reader

Overview:
- Drains stereo frames from buf_audio_in and forwards them to the DSP chain.
- Watches buffer_ready, pulses adv_read_enable once per frame, and captures audio_channel_out after a fixed read latency.
- Presents each frame on a valid/ready stream.
- Keeps frame and overflow statistics for debug.

Parameters:
- NUM_AUDIO_CHANNELS, 1, number of stereo pairs; matches buf_audio_in.
- AUDIO_WIDTH, 24, bits per mono sample.
- READ_LATENCY, 1, sys_clk cycles from the adv_read_enable cycle to valid audio_channel_out data. Legal range is 1..7.
- Derived: FRAME_W = NUM_AUDIO_CHANNELS*2*AUDIO_WIDTH. Mono channel k occupies bits [k*AUDIO_WIDTH +: AUDIO_WIDTH], with k = pair*2 + lr and lr 0 = Left.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  permits new read requests.
- buffer_ready  input  1  from buf_audio_in; high when at least one frame is stored.
- buffer_full  input  1  from buf_audio_in; high when the buffer is full.
- audio_channel_in  input  FRAME_W  flattened audio_channel_out from buf_audio_in.
- adv_read_enable  output  1  pop request to buf_audio_in; one frame per cycle asserted.
- frame_valid  output  1  frame_data holds a captured frame.
- frame_ready  input  1  downstream accepts the frame.
- frame_data  output  FRAME_W  captured frame.
- frame_count  output  32  accepted frames; wraps modulo 2^32.
- full_events  output  16  rising edges of buffer_full; saturates at 16'hFFFF.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (sys_rst=0, async): state IDLE, all outputs 0, latency counter 0, buffer_full edge register 0. Release is synchronised internally through a 2-flop stage before leaving IDLE.
- All outputs are registered. The FSM has states IDLE, REQ, WAIT, HOLD.
- IDLE: enable && buffer_ready -> REQ; otherwise stay.
- REQ: adv_read_enable=1 for exactly this one cycle (cycle T). Load latency counter with READ_LATENCY -> WAIT.
- WAIT: decrement counter each cycle. In the cycle where the counter reaches 1 (cycle T+READ_LATENCY):
  - capture audio_channel_in into frame_data;
  - go to HOLD;
  - frame_valid is high from cycle T+READ_LATENCY+1.
- HOLD: frame_valid=1 and frame_data stable until the handshake.
- Handshake: a cycle with frame_valid && frame_ready.
  - Next cycle: frame_valid=0 and frame_count+1.
  - If enable && buffer_ready in the handshake cycle -> REQ (back-to-back); else -> IDLE.
  - Minimum period is READ_LATENCY+2 cycles per frame.
- adv_read_enable is never asserted outside REQ. It is never asserted while frame_valid=1, so at most one frame is in flight.
- enable deasserted mid-transaction: the current transaction completes through the handshake; no new REQ is issued.
- buffer_ready drop during WAIT: capture proceeds regardless. The pop was already issued, so the data is the popped frame.
- full_events increments on each 0->1 transition of buffer_full sampled on sys_clk, in any state, and holds at 16'hFFFF.
- frame_ready while frame_valid=0 is ignored.
- Reset mid-operation: everything is immediately cleared to reset values. The pending frame is discarded and frame_count is not incremented.

Test Plan:
- Reset with frame_valid=1 and frame_count=5 -> all outputs 0 asynchronously, before the next sys_clk edge.
- READ_LATENCY=1, enable=1, frame_ready=1, buffer_ready 0->1, audio_channel_in={R=24'hABCDEF, L=24'h123456}:
  - adv_read_enable is a single pulse in cycle T;
  - frame_valid rises in T+2 with frame_data[23:0]=24'h123456 and frame_data[47:24]=24'hABCDEF;
  - frame_count=1 in T+3.
- buffer_ready held high, frame_ready=1, 8 frames with L=24'h100000+i, R=24'h200000+i:
  - adv_read_enable pulses every 3 cycles;
  - frames arrive in order;
  - frame_count=8.
- frame_ready=0 for 20 cycles with buffer_ready=1 -> frame_valid stays high, frame_data is stable, and no further adv_read_enable pulse occurs. Raising frame_ready -> one handshake, then the next REQ one cycle later.
- enable dropped in the REQ cycle -> the frame still completes. Afterwards adv_read_enable stays 0 despite buffer_ready=1, and busy=0.
- buffer_full toggled 0->1->0 three times -> full_events=3. With full_events forced near the limit, 70000 edges -> full_events=16'hFFFF.

Source files
------------

// File: rtl/audio_in_frame_reader.sv
// Pops one stereo frame per request from buf_audio_in and presents it on a valid/ready stream.
// Latency: frame_valid rises READ_LATENCY+1 cycles after the adv_read_enable pulse.
// Backpressure: at most one frame in flight; no new pop is issued until the held frame is accepted.
module audio_in_frame_reader #(
  parameter int NUM_AUDIO_CHANNELS = 1,
  parameter int AUDIO_WIDTH        = 24,
  parameter int READ_LATENCY       = 1,   // legal range 1..7 (3-bit latency counter)
  localparam int FRAME_W           = NUM_AUDIO_CHANNELS * 2 * AUDIO_WIDTH
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic               buffer_ready,
  input  logic               buffer_full,
  input  logic [FRAME_W-1:0] audio_channel_in,
  output logic               adv_read_enable,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic [31:0]        frame_count,
  output logic [15:0]        full_events,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lat_cnt;
  logic [2:0] lat_cnt_nxt;
  logic [1:0] rst_sync;
  logic       run_ok;
  logic       capture;
  logic       handshake;
  logic       full_q;

  assign run_ok    = rst_sync[1];
  assign handshake = frame_valid && frame_ready;

  // Two-flop synchroniser on reset release; IDLE is held until it has propagated.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // Next-state logic: request, wait out the buffer read latency, hold until accepted.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (run_ok && enable && buffer_ready) state_nxt = REQ;
      end
      REQ: begin
        lat_cnt_nxt = 3'(READ_LATENCY);
        state_nxt   = WAIT;
      end
      WAIT: begin
        // The pop is already committed, so buffer_ready is not consulted here.
        if (lat_cnt == 3'd1) begin
          capture     = 1'b1;
          lat_cnt_nxt = 3'd0;
          state_nxt   = HOLD;
        end else begin
          lat_cnt_nxt = lat_cnt - 3'd1;
        end
      end
      HOLD: begin
        if (handshake) state_nxt = (enable && buffer_ready) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered stream/control outputs, all derived from the next state.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state           <= IDLE;
      lat_cnt         <= 3'd0;
      adv_read_enable <= 1'b0;
      frame_valid     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      lat_cnt         <= lat_cnt_nxt;
      adv_read_enable <= (state_nxt == REQ);
      frame_valid     <= (state_nxt == HOLD);
      busy            <= (state_nxt != IDLE);
    end
  end

  // Frame capture and accepted-frame counter.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      frame_data  <= '0;
      frame_count <= 32'd0;
    end else begin
      if (capture)   frame_data  <= audio_channel_in;
      if (handshake) frame_count <= frame_count + 32'd1;
    end
  end

  // Count rising edges of buffer_full in any state, saturating at all-ones.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      full_q      <= 1'b0;
      full_events <= 16'd0;
    end else begin
      full_q <= buffer_full;
      if (buffer_full && !full_q && (full_events != 16'hFFFF))
        full_events <= full_events + 16'd1;
    end
  end

endmodule

// File: tb/tb_audio_in_frame_reader.sv
module tb_audio_in_frame_reader;
  localparam int AW  = 24;
  localparam int NCH = 1;
  localparam int RL  = 1;
  localparam int FW  = NCH * 2 * AW;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          enable = 1'b0;
  logic          buffer_ready = 1'b0;
  logic          buffer_full = 1'b0;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] audio_channel_in = '0;
  logic          adv_read_enable;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic [31:0]   frame_count;
  logic [15:0]   full_events;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Behavioural world: buffer contents, popped-but-unaccepted frames, accepted frames.
  logic [FW-1:0] bufq[$];
  logic [FW-1:0] expq[$];
  logic [FW-1:0] rx[$];
  typedef struct {int due; logic [FW-1:0] dat;} pend_t;
  pend_t pend[$];
  int    adv_times[$];
  int    exp_count = 0;
  int    exp_full  = 0;
  logic  prev_full = 1'b0;

  typedef struct {logic [AW-1:0] l; logic [AW-1:0] r; logic [FW-1:0] exp;} vec_t;
  vec_t vec[8];

  always #5 sys_clk = ~sys_clk;

  audio_in_frame_reader #(
    .NUM_AUDIO_CHANNELS(NCH), .AUDIO_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .buffer_ready(buffer_ready), .buffer_full(buffer_full),
    .audio_channel_in(audio_channel_in), .adv_read_enable(adv_read_enable),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_count(frame_count), .full_events(full_events), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, required none", name);
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic [AW-1:0] l, input logic [AW-1:0] r);
    logic [FW-1:0] f;
    f = '0;
    f[0 +: AW]  = l;
    f[AW +: AW] = r;
    return f;
  endfunction

  // Runs at a falling edge: outputs are stable and inputs are set for the next rising edge.
  task automatic model_eval();
    logic [FW-1:0] f;
    check("frame_count", 64'(frame_count), 64'(exp_count));
    check("full_events", 64'(full_events), 64'(exp_full));
    // buffer_in presents a popped frame READ_LATENCY cycles after the pop
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      audio_channel_in = pend[0].dat;
      void'(pend.pop_front());
    end else begin
      audio_channel_in = FW'({$urandom(), $urandom()});
    end
    if (adv_read_enable) begin
      adv_times.push_back(cyc_n);
      check("adv_while_valid", 64'(frame_valid), 64'(0));
      if (bufq.size() == 0) fail("pop_from_empty");
      else begin
        f = bufq.pop_front();
        expq.push_back(f);
        pend.push_back('{cyc_n + RL, f});
      end
    end
    if (frame_valid && frame_ready) begin
      rx.push_back(frame_data);
      if (expq.size() == 0) fail("unexpected_frame");
      else check("frame_order", 64'(frame_data), 64'(expq.pop_front()));
      exp_count++;
    end
    if (buffer_full && !prev_full && exp_full < 65535) exp_full++;
    prev_full    = buffer_full;
    buffer_ready = (bufq.size() > 0);
  endtask

  task automatic cyc();
    model_eval();
    @(negedge sys_clk);
    cyc_n++;
  endtask

  task automatic wait_adv(input string name);
    int n;
    n = 0;
    while (!adv_read_enable && n < 30) begin cyc(); n++; end
    if (!adv_read_enable) fail(name);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!frame_valid && n < 30) begin cyc(); n++; end
    if (!frame_valid) fail(name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adv"},   64'(adv_read_enable), 64'(0));
    check({tag, "_valid"}, 64'(frame_valid), 64'(0));
    check({tag, "_data"},  64'(frame_data), 64'(0));
    check({tag, "_count"}, 64'(frame_count), 64'(0));
    check({tag, "_full"},  64'(full_events), 64'(0));
    check({tag, "_busy"},  64'(busy), 64'(0));
  endtask

  initial begin
    logic [FW-1:0] d;
    int n;
    int base;
    for (int i = 0; i < 8; i++) begin
      vec[i].l   = 24'(24'h100000 + i);
      vec[i].r   = 24'(24'h200000 + i);
      vec[i].exp = {vec[i].r, vec[i].l};
    end

    // reset values
    #3;
    check_all_zero("rst");
    @(negedge sys_clk);
    sys_rst = 1'b1; enable = 1'b1; frame_ready = 1'b1;
    repeat (4) cyc();

    // single frame: pulse at T, valid at T+2, count at T+3
    bufq.push_back(mk_frame(24'h123456, 24'hABCDEF));
    wait_adv("t1_adv_timeout");
    cyc();
    check("t1_adv_single", 64'(adv_read_enable), 64'(0));
    check("t1_valid_early", 64'(frame_valid), 64'(0));
    cyc();
    check("t1_valid", 64'(frame_valid), 64'(1));
    check("t1_left", 64'(frame_data[23:0]), 64'(24'h123456));
    check("t1_right", 64'(frame_data[47:24]), 64'(24'hABCDEF));
    cyc();
    check("t1_count", 64'(frame_count), 64'(1));
    check("t1_valid_drop", 64'(frame_valid), 64'(0));

    // eight back-to-back frames from the vector table
    rx.delete(); adv_times.delete();
    foreach (vec[i]) bufq.push_back(mk_frame(vec[i].l, vec[i].r));
    n = 0;
    while (rx.size() < 8 && n < 100) begin cyc(); n++; end
    if (rx.size() < 8) fail("t2_timeout");
    for (int i = 0; i < 8; i++)
      if (i < rx.size()) check($sformatf("t2_frame%0d", i), 64'(rx[i]), 64'(vec[i].exp));
    check("t2_pulses", 64'(adv_times.size()), 64'(8));
    for (int i = 1; i < adv_times.size(); i++)
      check($sformatf("t2_gap%0d", i), 64'(adv_times[i] - adv_times[i-1]), 64'(3));
    check("t2_count", 64'(frame_count), 64'(9));

    // downstream stall for 20 cycles
    frame_ready = 1'b0; adv_times.delete();
    bufq.push_back(FW'({$urandom(), $urandom()}));
    bufq.push_back(FW'({$urandom(), $urandom()}));
    wait_valid("t3_valid_timeout");
    d = frame_data;
    repeat (20) begin
      cyc();
      check("t3_hold", 64'({frame_valid, frame_data == d, adv_read_enable}), 64'(3'b110));
    end
    check("t3_one_pop", 64'(adv_times.size()), 64'(1));
    frame_ready = 1'b1;
    cyc();
    check("t3_valid_after_hs", 64'(frame_valid), 64'(0));
    check("t3_req_next", 64'(adv_read_enable), 64'(1));
    repeat (8) cyc();
    check("t3_drained", 64'(bufq.size()), 64'(0));

    // enable dropped during REQ
    adv_times.delete();
    bufq.push_back(FW'({$urandom(), $urandom()}));
    bufq.push_back(FW'({$urandom(), $urandom()}));
    base = exp_count;
    wait_adv("t4_adv_timeout");
    enable = 1'b0;
    repeat (10) cyc();
    check("t4_one_pulse", 64'(adv_times.size()), 64'(1));
    check("t4_completed", 64'(exp_count), 64'(base + 1));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_buf_ready", 64'(buffer_ready), 64'(1));

    // three buffer_full pulses
    repeat (3) begin
      buffer_full = 1'b1; cyc();
      buffer_full = 1'b0; cyc();
    end
    cyc();
    check("t5_full_events", 64'(full_events), 64'(3));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      frame_ready = ($urandom_range(0, 2) != 0);
      buffer_full = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0 && bufq.size() < 6)
        bufq.push_back(FW'({$urandom(), $urandom()}));
      cyc();
    end
    enable = 1'b1; frame_ready = 1'b1; buffer_full = 1'b0;
    n = 0;
    while ((bufq.size() > 0 || busy) && n < 100) begin cyc(); n++; end
    cyc();
    check("t6_drained", 64'(bufq.size()), 64'(0));
    check("t6_idle", 64'(busy), 64'(0));

    // full_events saturation from near the limit
    force dut.full_events = 16'hFFF0;
    #1;
    release dut.full_events;
    exp_full = 16'hFFF0;
    repeat (20) begin
      buffer_full = 1'b1; cyc();
      buffer_full = 1'b0; cyc();
    end
    check("t7_saturate", 64'(full_events), 64'(16'hFFFF));

    // asynchronous reset with a frame pending
    frame_ready = 1'b0;
    bufq.push_back(FW'({$urandom(), $urandom()}));
    wait_valid("t8_valid_timeout");
    check("t8_count_nonzero", 64'(frame_count != 0), 64'(1));
    #2 sys_rst = 1'b0;
    #1 check_all_zero("t8_async");
    @(negedge sys_clk);
    sys_rst = 1'b1;
    expq.delete(); pend.delete();
    exp_count = 0; exp_full = 0; prev_full = 1'b0;
    frame_ready = 1'b1;
    repeat (10) cyc();
    check("t8_discarded", 64'(frame_count), 64'(0));
    check("t8_valid_low", 64'(frame_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
